// File: rtl/am2901_microseq_if.sv
// Sequencer-side bundle: start request, microcode ROM port,
// controller flags in and issued opcode/operand fields out.
interface am2901_microseq_if #(
    parameter int UADDR_W = 6
);
    logic               start;
    logic [UADDR_W-1:0] start_addr;
    logic [UADDR_W-1:0] uaddr;
    logic [31:0]        uword;
    logic               z;
    logic               ovr;
    logic [8:0]         i;
    logic [3:0]         a;
    logic [3:0]         b;
    logic [3:0]         d;
    logic               oe;
    logic               busy;
    logic               done;
    logic               err;

    modport master (
        input  start, start_addr, uword, z, ovr,
        output uaddr, i, a, b, d, oe, busy, done, err
    );

    modport slave (
        output start, start_addr, uword, z, ovr,
        input  uaddr, i, a, b, d, oe, busy, done, err
    );
endinterface

// File: rtl/am2901_microseq.sv
// Am2901 microprogram sequencer: pipeline register, next-address
// logic with flag branches, return stack and loop counter.
module am2901_microseq #(
    parameter int UADDR_W     = 6,
    parameter int STACK_DEPTH = 4
) (
    input logic                clk,
    input logic                rst_n,
    am2901_microseq_if.master  bus
);
    localparam int SPW = $clog2(STACK_DEPTH + 1);
    localparam int IW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [2:0] OP_CONT  = 3'd0;
    localparam logic [2:0] OP_JMP   = 3'd1;
    localparam logic [2:0] OP_JCOND = 3'd2;
    localparam logic [2:0] OP_CALL  = 3'd3;
    localparam logic [2:0] OP_RET   = 3'd4;
    localparam logic [2:0] OP_LDCNT = 3'd5;
    localparam logic [2:0] OP_LOOP  = 3'd6;
    localparam logic [2:0] OP_HALT  = 3'd7;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t             state_q, state_d;
    logic [31:0]        pipe_q;
    logic [UADDR_W-1:0] cur_q;
    logic [5:0]         cnt_q;
    logic [SPW-1:0]     sp_q;
    logic [UADDR_W-1:0] stk_q [STACK_DEPTH];
    logic               err_q;
    logic               done_q;

    logic [2:0]         op;
    logic [UADDR_W-1:0] tgt;
    logic [UADDR_W-1:0] inc;
    logic [UADDR_W-1:0] top;
    logic [UADDR_W-1:0] nxt_d;
    logic               flag;
    logic               fault;

    assign op    = pipe_q[24:22];
    assign tgt   = UADDR_W'(pipe_q[30:25]);
    assign inc   = cur_q + UADDR_W'(1);
    assign top   = stk_q[IW'(sp_q - SPW'(1))];
    assign flag  = pipe_q[31] ? bus.ovr : bus.z;
    assign fault = (op == OP_CALL && sp_q == SPW'(STACK_DEPTH)) ||
                   (op == OP_RET  && sp_q == '0);

    always_comb begin
        nxt_d = inc;
        case (op)
            OP_JMP,
            OP_CALL:  nxt_d = tgt;
            OP_JCOND: if (flag) nxt_d = tgt;
            OP_RET:   nxt_d = top;
            OP_LOOP:  if (cnt_q != '0) nxt_d = tgt;
            default:  nxt_d = inc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_RUN;
            S_RUN:   if (fault || op == OP_HALT) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.uaddr = bus.start_addr;
        bus.i     = 9'h040;
        bus.a     = '0;
        bus.b     = '0;
        bus.d     = '0;
        bus.oe    = 1'b0;
        bus.busy  = 1'b0;
        bus.done  = done_q;
        bus.err   = err_q;
        if (state_q == S_RUN) begin
            bus.uaddr = nxt_d;
            bus.i     = pipe_q[8:0];
            bus.a     = pipe_q[12:9];
            bus.b     = pipe_q[16:13];
            bus.d     = pipe_q[20:17];
            bus.oe    = pipe_q[21];
            bus.busy  = 1'b1;
        end
    end

    // Faults and HALT freeze pipe/cur/stack; only flags move.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= '0;
            cur_q  <= '0;
            cnt_q  <= '0;
            sp_q   <= '0;
            err_q  <= 1'b0;
            done_q <= 1'b0;
            for (int k = 0; k < STACK_DEPTH; k++) stk_q[k] <= '0;
        end else begin
            done_q <= 1'b0;
            if (state_q == S_IDLE) begin
                if (bus.start) begin
                    pipe_q <= bus.uword;
                    cur_q  <= bus.start_addr;
                    sp_q   <= '0;
                    err_q  <= 1'b0;
                end
            end else if (fault) begin
                err_q <= 1'b1;
            end else if (op == OP_HALT) begin
                done_q <= 1'b1;
            end else begin
                pipe_q <= bus.uword;
                cur_q  <= nxt_d;
                if (op == OP_CALL) begin
                    stk_q[IW'(sp_q)] <= inc;
                    sp_q             <= sp_q + SPW'(1);
                end
                if (op == OP_RET) sp_q <= sp_q - SPW'(1);
                if (op == OP_LDCNT) cnt_q <= pipe_q[30:25];
                if (op == OP_LOOP && cnt_q != '0) cnt_q <= cnt_q - 6'd1;
            end
        end
    end
endmodule

// File: tb/tb_am2901_microseq.sv
// Bench for am2901_microseq: ROM model, vector table of programs,
// queue of expected issue addresses checked each RUN cycle.
module tb_am2901_microseq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    am2901_microseq_if #(.UADDR_W(6)) bus ();

    am2901_microseq #(.UADDR_W(6), .STACK_DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] rom [64];
    assign bus.uword = rom[bus.uaddr];

    typedef struct {
        int   scen;
        int   sa;
        logic z;
        logic ovr;
        int   n;
        int   seq [8];
        logic xdone;
        logic xerr;
    } vec_t;

    vec_t vt [12];
    int   nv = 0;
    int   sb [$];

    function automatic logic [31:0] w(input logic [2:0] op,
                                      input logic [5:0] t,
                                      input logic c,
                                      input logic [5:0] ad);
        return {c, t, op, 1'b1, ad[3:0], 4'h0, ad[3:0], 3'b100, ad};
    endfunction

    function automatic logic [8:0] ei(input int ad);
        logic [5:0] a6;
        a6 = 6'(ad);
        return {3'b100, a6};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input int s, input int sa, input logic z,
                       input logic o, input int n,
                       input int a0, input int a1, input int a2,
                       input int a3, input int a4, input int a5,
                       input logic xd, input logic xe);
        vt[nv].scen  = s;
        vt[nv].sa    = sa;
        vt[nv].z     = z;
        vt[nv].ovr   = o;
        vt[nv].n     = n;
        vt[nv].seq[0] = a0;
        vt[nv].seq[1] = a1;
        vt[nv].seq[2] = a2;
        vt[nv].seq[3] = a3;
        vt[nv].seq[4] = a4;
        vt[nv].seq[5] = a5;
        vt[nv].seq[6] = 0;
        vt[nv].seq[7] = 0;
        vt[nv].xdone = xd;
        vt[nv].xerr  = xe;
        nv++;
    endtask

    task automatic setup(input int s);
        for (int k = 0; k < 64; k++) rom[k] = w(3'd0, 6'd0, 1'b0, 6'(k));
        case (s)
            0: rom[7] = w(3'd7, 6'd0, 1'b0, 6'd7);
            1, 2: begin
                rom[0]  = w(3'd2, 6'd20, (s == 2), 6'd0);
                rom[20] = w(3'd7, 6'd0, 1'b0, 6'd20);
                rom[1]  = w(3'd7, 6'd0, 1'b0, 6'd1);
            end
            3, 4: begin
                rom[0]  = w(3'd3, 6'd10, 1'b0, 6'd0);
                rom[10] = w(3'd4, 6'd0, 1'b0, 6'd10);
                rom[1]  = w((s == 3) ? 3'd7 : 3'd4, 6'd0, 1'b0, 6'd1);
            end
            5: begin
                rom[0] = w(3'd5, 6'd3, 1'b0, 6'd0);
                rom[1] = w(3'd6, 6'd1, 1'b0, 6'd1);
                rom[2] = w(3'd7, 6'd0, 1'b0, 6'd2);
            end
            6: begin
                for (int k = 0; k < 5; k++)
                    rom[k] = w(3'd3, 6'(k + 1), 1'b0, 6'(k));
                rom[5] = w(3'd7, 6'd0, 1'b0, 6'd5);
            end
            7: rom[8] = w(3'd4, 6'd0, 1'b0, 6'd8);
            8: rom[0] = w(3'd7, 6'd0, 1'b0, 6'd0);
            default: ;
        endcase
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int cyc;
        int ea;
        setup(v.scen);
        bus.z   = v.z;
        bus.ovr = v.ovr;
        sb.delete();
        for (int k = 0; k < v.n; k++) sb.push_back(v.seq[k]);
        @(negedge clk);
        bus.start_addr = 6'(v.sa);
        bus.start      = 1'b1;
        #1 chk($sformatf("v%0d uaddr_idle", idx), 32'(bus.uaddr), 32'(v.sa));
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d err_clr", idx), 32'(bus.err), 32'd0);
        cyc = 0;
        while (bus.busy && cyc < 40) begin
            if (sb.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL v%0d extra_issue: got i=%0h expected none",
                         idx, bus.i);
            end else begin
                ea = sb.pop_front();
                chk($sformatf("v%0d issue_i", idx), 32'(bus.i), 32'(ei(ea)));
                if (sb.size() > 0)
                    chk($sformatf("v%0d uaddr", idx), 32'(bus.uaddr),
                        32'(sb[0]));
            end
            cyc++;
            @(negedge clk);
        end
        chk($sformatf("v%0d timeout", idx), 32'(cyc < 40), 32'd1);
        chk($sformatf("v%0d missing", idx), 32'(sb.size()), 32'd0);
        chk($sformatf("v%0d done", idx), 32'(bus.done), 32'(v.xdone));
        chk($sformatf("v%0d err", idx), 32'(bus.err), 32'(v.xerr));
        chk($sformatf("v%0d idle_i", idx), 32'(bus.i), 32'h040);
        chk($sformatf("v%0d idle_oe", idx), 32'(bus.oe), 32'd0);
        @(negedge clk);
        chk($sformatf("v%0d done_pulse", idx), 32'(bus.done), 32'd0);
    endtask

    initial begin
        int cyc;
        bus.start      = 1'b0;
        bus.start_addr = '0;
        bus.z          = 1'b0;
        bus.ovr        = 1'b0;
        setup(0);

        add(0, 5, 0, 0, 3, 5, 6, 7, 0, 0, 0, 1, 0);
        add(1, 0, 1, 0, 2, 0, 20, 0, 0, 0, 0, 1, 0);
        add(1, 0, 0, 0, 2, 0, 1, 0, 0, 0, 0, 1, 0);
        add(1, 0, 0, 1, 2, 0, 1, 0, 0, 0, 0, 1, 0);
        add(2, 0, 0, 1, 2, 0, 20, 0, 0, 0, 0, 1, 0);
        add(2, 0, 1, 0, 2, 0, 1, 0, 0, 0, 0, 1, 0);
        add(3, 0, 0, 0, 3, 0, 10, 1, 0, 0, 0, 1, 0);
        add(4, 0, 0, 0, 3, 0, 10, 1, 0, 0, 0, 0, 1);
        add(5, 0, 0, 0, 6, 0, 1, 1, 1, 1, 2, 1, 0);
        add(6, 0, 0, 0, 5, 0, 1, 2, 3, 4, 0, 0, 1);
        add(7, 8, 0, 0, 1, 8, 0, 0, 0, 0, 0, 0, 1);
        add(8, 63, 0, 0, 2, 63, 0, 0, 0, 0, 0, 1, 0);

        #2;
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst done", 32'(bus.done), 32'd0);
        chk("rst err", 32'(bus.err), 32'd0);
        chk("rst i", 32'(bus.i), 32'h040);
        chk("rst abd", 32'({bus.a, bus.b, bus.d, bus.oe}), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int k = 0; k < nv; k++) run_vec(vt[k], k);

        // restart in the done cycle
        setup(0);
        @(negedge clk);
        bus.start_addr = 6'd5;
        bus.start      = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        cyc = 0;
        @(negedge clk);
        while (!bus.done && cyc < 20) begin
            cyc++;
            @(negedge clk);
        end
        chk("redone seen", 32'(bus.done), 32'd1);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        chk("restart busy", 32'(bus.busy), 32'd1);
        chk("restart i", 32'(bus.i), 32'(ei(5)));
        cyc = 0;
        while (bus.busy && cyc < 20) begin
            cyc++;
            @(negedge clk);
        end
        chk("restart done", 32'(bus.done), 32'd1);

        // asynchronous reset mid-run
        setup(8);
        @(negedge clk);
        bus.start_addr = 6'd63;
        bus.start      = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        chk("mid i63", 32'(bus.i), 32'(ei(63)));
        rst_n = 1'b0;
        #1;
        chk("mid rst busy", 32'(bus.busy), 32'd0);
        chk("mid rst i", 32'(bus.i), 32'h040);
        chk("mid rst oe", 32'(bus.oe), 32'd0);
        chk("mid rst uaddr", 32'(bus.uaddr), 32'd63);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("mid rst nodone", 32'(bus.done), 32'd0);
        chk("mid rst idle", 32'(bus.busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
